// File: rtl/mem1p11_dxw_p.sv
// Single-port synchronous SRAM soft model with registered read data.
// Optional: define MEM1P_WRITE_THROUGH_EN to return write data on dout.
module mem1p11_dxw_p #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 24,
    localparam int A = $clog2(DEPTH)
) (
    input  logic [A-1:0]     addr,
    input  logic [WIDTH-1:0] din,
    input  logic             me,
    input  logic             wnr,
    input  logic             clk,
    output logic [WIDTH-1:0] dout,
    input  logic             rst
);

    localparam int AW1 = A + 1;

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;
    logic             in_range;
    logic             ctl_x;
    logic             wr_en;

    // Only reachable when DEPTH is not a power of two.
    assign in_range = ({1'b0, addr} < AW1'(DEPTH));

`ifndef SYNTHESIS
    assign ctl_x = $isunknown(me) || (me && $isunknown({wnr, addr}));
`else
    assign ctl_x = 1'b0;
`endif

    assign wr_en = !rst && !ctl_x && me && wnr && in_range;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= din;
        end
    end

    always_comb begin
        dout_d = dout_q;
        if (rst) begin
            dout_d = '0;
        end else if (ctl_x) begin
            dout_d = 'x;
        end else if (me) begin
            if (wnr) begin
`ifdef MEM1P_WRITE_THROUGH_EN
                dout_d = din;
`else
                dout_d = dout_q;
`endif
            end else begin
                dout_d = in_range ? mem_q[addr] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        dout_q <= dout_d;
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_mem1p11_dxw_p.sv
// Directed bench for mem1p11_dxw_p: default 2048x24 and a 1000-deep instance.
module tb_mem1p11_dxw_p;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] addr = '0;
    logic [23:0] din = '0;
    logic        me = 1'b0;
    logic        wnr = 1'b0;
    logic [23:0] dout;

    logic [9:0]  addr2 = '0;
    logic [23:0] din2 = '0;
    logic        me2 = 1'b0;
    logic        wnr2 = 1'b0;
    logic [23:0] dout2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem1p11_dxw_p u_dut (
        .addr (addr),
        .din  (din),
        .me   (me),
        .wnr  (wnr),
        .clk  (clk),
        .dout (dout),
        .rst  (rst)
    );

    mem1p11_dxw_p #(.DEPTH(1000), .WIDTH(24)) u_dut1k (
        .addr (addr2),
        .din  (din2),
        .me   (me2),
        .wnr  (wnr2),
        .clk  (clk),
        .dout (dout2),
        .rst  (rst)
    );

    task automatic chk(input string tag, input logic [23:0] got,
                       input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic e, input logic w, input logic [10:0] a,
                       input logic [23:0] d);
        me = e;
        wnr = w;
        addr = a;
        din = d;
    endtask

    task automatic drv2(input logic e, input logic w, input logic [9:0] a,
                        input logic [23:0] d);
        me2 = e;
        wnr2 = w;
        addr2 = a;
        din2 = d;
    endtask

    initial begin
        // Reset with a write request pending
        rst = 1'b1;
        drv(1, 1, 11'd7, 24'h123456);
        step();
        chk("rst_c1", dout, 24'h0);
        step();
        chk("rst_c2", dout, 24'h0);
        chk("rst_1k", dout2, 24'h0);
        rst = 1'b0;

        drv(1, 1, 11'd1, 24'h000111);
        step();
        drv(1, 0, 11'd1, 24'h0);
        step();
        chk("rd1", dout, 24'h000111);

        drv(1, 1, 11'd0, 24'h000aaa);
        step();
`ifdef MEM1P_WRITE_THROUGH_EN
        chk("wr_dout", dout, 24'h000aaa);
`else
        chk("wr_hold", dout, 24'h000111);
`endif
        drv(1, 0, 11'd1, 24'h0);
        step();
        chk("rd1b", dout, 24'h000111);

        drv(0, 1, 11'd1, 24'habcdf0);
        step();
        chk("me0_hold", dout, 24'h000111);
        drv(1, 0, 11'd0, 24'h0);
        step();
        chk("rd0", dout, 24'h000aaa);
        drv(1, 0, 11'd1, 24'h0);
        step();
        chk("me0_nowr", dout, 24'h000111);

        drv(1, 0, 11'd7, 24'h0);
        step();
        chk("rst_nowr", {23'h0, dout !== 24'h123456}, 24'h1);

        for (int i = 0; i < 4; i++) begin
            drv(1, 1, 11'(3 + i), 24'habcdf2 + 24'(i));
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drv(1, 0, 11'(3 + i), 24'h0);
            step();
            chk($sformatf("burst%0d", i), dout, 24'habcdf2 + 24'(i));
        end

        drv(1, 0, 11'd3, 24'h0);
        step();
        chk("gate_rd3", dout, 24'habcdf2);
        drv(0, 0, 11'd4, 24'h0);
        step();
        chk("gate_hold", dout, 24'habcdf2);
        drv(1, 0, 11'd5, 24'h0);
        step();
        chk("gate_rd5", dout, 24'habcdf4);
        drv(1, 0, 11'd6, 24'h0);
        step();
        chk("gate_rd6", dout, 24'habcdf5);

        drv(1, 1, 11'd2047, 24'h00ffee);
        step();
`ifdef MEM1P_WRITE_THROUGH_EN
        chk("raw_wt", dout, 24'h00ffee);
`else
        chk("raw_hold", dout, 24'habcdf5);
`endif
        drv(1, 0, 11'd2047, 24'h0);
        step();
        chk("raw_rd", dout, 24'h00ffee);

        drv(1, 1, 11'd7, 24'h000777);
        step();
        rst = 1'b1;
        drv(1, 1, 11'd7, 24'h123456);
        step();
        chk("rst2", dout, 24'h0);
        rst = 1'b0;
        drv(1, 0, 11'd7, 24'h0);
        step();
        chk("rst2_rd7", dout, 24'h000777);
        drv(0, 0, 11'd0, 24'h0);

        // Out-of-range on the 1000-deep instance
        drv2(1, 1, 10'd5, 24'h5a5a5a);
        step();
        drv2(1, 1, 10'd1005, 24'hdeadbe);
        step();
        drv2(1, 0, 10'd5, 24'h0);
        step();
        chk("oor_rd5", dout2, 24'h5a5a5a);
        drv2(1, 0, 10'd1005, 24'h0);
        step();
        chk("oor_rd", dout2, 24'h0);
        drv2(1, 0, 10'd999, 24'h0);
        step();
        drv2(1, 1, 10'd999, 24'h0c0ffe);
        step();
        drv2(1, 0, 10'd999, 24'h0);
        step();
        chk("edge_999", dout2, 24'h0c0ffe);
        drv2(1, 0, 10'd5, 24'h0);
        step();
        chk("oor_rd5b", dout2, 24'h5a5a5a);
        drv2(0, 0, 10'd0, 24'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
